// File: rtl/pll_reset_sequencer_if.sv
// Lock/reset signal bundle between the PLL-side sequencer and the rest of the design.
// The sequencer drives the reset outputs; the consumer drives the PLL lock flag.
interface pll_reset_sequencer_if;
   logic       locked_in;
   logic       pll_rst;
   logic       rst_out;
   logic       ready;
   logic [7:0] relock_count;

   modport master (
      input  locked_in,
      output pll_rst,
      output rst_out,
      output ready,
      output relock_count
   );

   modport slave (
      output locked_in,
      input  pll_rst,
      input  rst_out,
      input  ready,
      input  relock_count
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Holds the design in reset until the PLL lock has been stable long enough,
// retrying the PLL on lock timeout and re-asserting reset on any loss of lock.
module pll_reset_sequencer #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 65536,
   parameter int unsigned CNT_W          = 17
) (
   input logic                    clock,
   input logic                    reset,
   pll_reset_sequencer_if.master  bus
);

   typedef enum logic [1:0] {StPllRst, StWait, StStable, StRun} state_t;

   localparam logic [CNT_W-1:0] PllLast     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_pll_rst;
   logic                   r_rst_out;
   logic                   r_ready;
   logic [7:0]             r_relock_count;
   logic                   w_lock_s;

   assign w_lock_s         = r_sync[SYNC_STAGES-1];
   assign bus.pll_rst      = r_pll_rst;
   assign bus.rst_out      = r_rst_out;
   assign bus.ready        = r_ready;
   assign bus.relock_count = r_relock_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= StPllRst;
         r_cnt          <= '0;
         r_sync         <= '0;
         r_pll_rst      <= 1'b0;
         r_rst_out      <= 1'b1;
         r_ready        <= 1'b0;
         r_relock_count <= 8'd0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.locked_in};
         unique case (r_state)
            StPllRst: begin
               // First edge after reset only raises the request; counting starts with it high.
               if (!r_pll_rst) begin
                  r_pll_rst <= 1'b1;
                  r_cnt     <= '0;
               end else if (r_cnt == PllLast) begin
                  r_state   <= StWait;
                  r_cnt     <= '0;
                  r_pll_rst <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StWait: begin
               if (w_lock_s) begin
                  r_state <= StStable;
                  r_cnt   <= '0;
               end else if (r_cnt == TimeoutLast) begin
                  r_state   <= StPllRst;
                  r_cnt     <= '0;
                  r_pll_rst <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StStable: begin
               if (!w_lock_s) begin
                  r_state <= StWait;
                  r_cnt   <= '0;
               end else if (r_cnt == StableLast) begin
                  r_state   <= StRun;
                  r_cnt     <= '0;
                  r_rst_out <= 1'b0;
                  r_ready   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StRun: begin
               if (!w_lock_s) begin
                  r_state   <= StWait;
                  r_cnt     <= '0;
                  r_rst_out <= 1'b1;
                  r_ready   <= 1'b0;
                  if (r_relock_count != 8'hff) begin
                     r_relock_count <= r_relock_count + 8'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised bench: a driver feeds reset/lock and queues model predictions,
// a monitor pops one prediction per clock and compares it with the outputs.
module tb_pll_reset_sequencer;

   localparam int unsigned SyncStages = 2;
   localparam int unsigned PllRst     = 4;
   localparam int unsigned Stable     = 8;
   localparam int unsigned Timeout    = 32;

   // Model phases: PLL being reset, waiting for lock, qualifying lock, running.
   localparam int MPulse = 0;
   localparam int MWait  = 1;
   localparam int MQual  = 2;
   localparam int MRun   = 3;

   typedef struct packed {
      logic       pll;
      logic       rsto;
      logic       rdy;
      logic [7:0] rc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   pll_reset_sequencer_if bus ();

   always #5 clock = ~clock;

   pll_reset_sequencer #(
      .SYNC_STAGES    (SyncStages),
      .PLL_RST_CYCLES (PllRst),
      .STABLE_CYCLES  (Stable),
      .TIMEOUT_CYCLES (Timeout),
      .CNT_W          (17)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   bit   done  = 1'b0;

   int m_mode   = MPulse;
   int m_served = 0;
   int m_waited = 0;
   int m_seen   = 0;
   int m_rc     = 0;
   bit m_pll    = 1'b0;
   bit m_rsto   = 1'b1;
   bit m_hist[$];

   // Predict the outputs after the coming edge from reset/lock seen at that edge.
   task automatic model(input bit r, input bit l);
      bit   ls;
      exp_t e;
      ls = m_hist[0];
      if (r) begin
         m_mode = MPulse; m_served = 0; m_pll = 1'b0; m_rsto = 1'b1; m_rc = 0;
         m_hist.delete();
         for (int i = 0; i < SyncStages; i++) m_hist.push_back(1'b0);
      end else begin
         void'(m_hist.pop_front());
         m_hist.push_back(l);
         case (m_mode)
            MPulse: begin
               if (!m_pll) begin
                  m_pll = 1'b1; m_served = 1;
               end else if (m_served == PllRst) begin
                  m_pll = 1'b0; m_mode = MWait; m_waited = 0;
               end else begin
                  m_served++;
               end
            end
            MWait: begin
               if (ls) begin
                  m_mode = MQual; m_seen = 1;
               end else if (m_waited + 1 == Timeout) begin
                  m_mode = MPulse; m_pll = 1'b1; m_served = 1;
               end else begin
                  m_waited++;
               end
            end
            MQual: begin
               if (!ls) begin
                  m_mode = MWait; m_waited = 0;
               end else if (m_seen == Stable) begin
                  m_mode = MRun; m_rsto = 1'b0;
               end else begin
                  m_seen++;
               end
            end
            default: begin
               if (!ls) begin
                  m_mode = MWait; m_waited = 0; m_rsto = 1'b1;
                  if (m_rc < 255) m_rc++;
               end
            end
         endcase
      end
      e.pll = m_pll; e.rsto = m_rsto; e.rdy = !m_rsto; e.rc = 8'(m_rc);
      q.push_back(e);
   endtask

   task automatic step(input bit r, input bit l);
      @(negedge clock);
      reset         = r;
      bus.locked_in = l;
      model(r, l);
   endtask

   task automatic hold(input bit l, input int n);
      for (int i = 0; i < n; i++) step(1'b0, l);
   endtask

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, req);
      end
   endtask

   // Monitor: outputs are registered, so every clock presents a new output word.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pll_rst", int'(bus.pll_rst), int'(e.pll));
            check("rst_out", int'(bus.rst_out), int'(e.rsto));
            check("ready", int'(bus.ready), int'(e.rdy));
            check("relock_count", int'(bus.relock_count), int'(e.rc));
         end
      end
   end

   initial begin
      int n;
      bit l;
      bus.locked_in = 1'b0;
      for (int i = 0; i < SyncStages; i++) m_hist.push_back(1'b0);
      repeat (3) step(1'b1, 1'b0);

      // Clean bring-up
      hold(1'b0, 10);
      hold(1'b1, 30);

      // Lock glitch during qualification
      step(1'b1, 1'b0);
      hold(1'b0, 6);
      hold(1'b1, 5);
      hold(1'b0, 1);
      hold(1'b1, 25);

      // Timeout retries with no lock
      step(1'b1, 1'b0);
      hold(1'b0, 120);

      // Lock loss while running
      step(1'b1, 1'b0);
      hold(1'b0, 6);
      hold(1'b1, 20);
      hold(1'b0, 3);
      hold(1'b1, 20);

      // Relock counter saturation
      for (int i = 0; i < 300; i++) begin
         hold(1'b0, int'($urandom_range(1, 3)));
         hold(1'b1, 14);
      end

      // Mid-operation reset in running and in qualifying phases
      step(1'b1, 1'b1);
      hold(1'b1, 20);
      step(1'b1, 1'b1);
      hold(1'b1, 10);
      step(1'b1, 1'b1);
      hold(1'b1, 20);

      // Random lock activity with occasional resets
      for (int i = 0; i < 150; i++) begin
         l = 1'($urandom_range(0, 3) != 0);
         n = int'($urandom_range(1, 40));
         if ($urandom_range(0, 19) == 0) step(1'b1, l);
         hold(l, n);
      end

      hold(1'b1, 2);
      done = 1'b1;
   end

   initial begin
      int guard;
      guard = 0;
      while (!done && guard < 90000) begin
         @(posedge clock);
         guard++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL stimulus_timeout: got running want done");
      end
      repeat (3) @(posedge clock);
      #2;
      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the ECP5 PLL wrapper. Consumes the PLL `locked` flag and produces the design-wide active-high reset plus a PLL reset request.
- Clocked by the free-running board oscillator (25 MHz), never by a PLL output, so it keeps running while the PLL is held in reset.
- Holds the design in reset until lock has been continuously stable for a programmable time.
- Retries the PLL if lock does not arrive within a timeout, and re-asserts reset on any loss of lock.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising `locked_in`; legal range 2..4.
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per attempt; must be >= SYNC_STAGES+2.
- STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before reset release; >= 1.
- TIMEOUT_CYCLES, 65536: cycles in WAIT without lock before a PLL retry; >= 1.
- CNT_W, 17: shared counter width; must hold max(PLL_RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES)-1.

Ports:
- clock  in  1  free-running oscillator clock; only clock of the block
- reset  in  1  synchronous, active-high
- locked_in  in  1  PLL lock flag, asynchronous to `clock`
- pll_rst  out  1  PLL reset request, active-high
- rst_out  out  1  design reset, active-high, synchronous to `clock`
- ready  out  1  high while design is running on a locked PLL
- relock_count  out  8  saturating count of lock losses seen in RUN

Behaviour:
- Interface: one clock (`clock`); reset is synchronous and active-high (`reset`). All flops update on rising `clock`, and `reset` is sampled only on that edge.
- All outputs are registered; no combinational path from any input to any output.
- `lock_s` is `locked_in` after SYNC_STAGES flops. Synchroniser flops reset to 0.
- Reset values while `reset`=1:
  - state=PLLRST, cnt=0
  - pll_rst=0, rst_out=1, ready=0, relock_count=0
- Reset asserted mid-operation: same values at the next edge, from any state. The sequence restarts and relock_count is cleared.
- PLLRST:
  - pll_rst=1 for exactly PLL_RST_CYCLES cycles, starting the edge after reset deasserts; cnt counts 0..PLL_RST_CYCLES-1.
  - lock_s is ignored (stale lock is flushed here).
  - On the last count: state=WAIT, cnt=0, pll_rst=0.
- WAIT (rst_out=1, ready=0):
  - lock_s=1: state=STABLE, cnt=0.
  - Else, cnt==TIMEOUT_CYCLES-1: state=PLLRST, cnt=0 (retry; relock_count unchanged).
  - Else: cnt+1.
- STABLE (rst_out=1, ready=0):
  - lock_s=0: state=WAIT, cnt=0 (timeout restarts from zero).
  - Else, cnt==STABLE_CYCLES-1: state=RUN, and rst_out=0, ready=1 on that same edge.
  - Else: cnt+1.
  - Latency: if lock_s is first seen at edge k in WAIT, rst_out falls at edge k+STABLE_CYCLES, given no glitch.
- RUN (rst_out=0, ready=1):
  - lock_s=0: at that edge state=WAIT, cnt=0, rst_out=1, ready=0, relock_count+1, saturating at 255.
  - PLL is not reset on lock loss; reset is re-requested only on WAIT timeout.
- Simultaneous events:
  - `reset` overrides everything.
  - In STABLE, lock_s=0 on the terminal count takes priority: go to WAIT, no release.
  - In WAIT, lock_s=1 on the timeout cycle takes priority: go to STABLE, no retry.
- Invariants: pll_rst=1 implies rst_out=1; ready is always the complement of rst_out; only pll_rst=1 in PLLRST.
- Counter never wraps: every terminal compare resets cnt. relock_count holds at 255.

Test Plan:
Bench values: SYNC_STAGES=2, PLL_RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32.
- Clean bring-up: release reset, raise locked_in 10 cycles later and hold -> pll_rst high for exactly 4 cycles; rst_out falls exactly 2+8 edges after locked_in rises, counted from WAIT; ready=1, relock_count=0.
- Lock glitch: locked_in high 5 cycles, low 1, then high -> no release at the first window; rst_out falls 8 cycles after the second lock_s rise.
- Timeout retry: hold locked_in=0 -> pll_rst pulses of 4 cycles repeat every 4+32 cycles; rst_out stays 1 throughout.
- Lock loss in RUN: in RUN, drop locked_in 3 cycles -> rst_out=1 two edges later; relock_count=1; re-release 8 cycles after lock returns; pll_rst stays 0.
- Saturation: 300 lock losses in RUN -> relock_count=255.
- Mid-operation reset: assert reset for 1 cycle during RUN and during STABLE -> next edge rst_out=1, ready=0, relock_count=0, state PLLRST; full 4-cycle pll_rst pulse follows.
